// File: rtl/cart_loader_pkg.sv
// Shared types and constants for the cart_loader boot-time stream writer.
// State encodings, default framing bytes and the LEN=0 interpretation live here.
package cart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN,
        DATA,
        CHK,
        DONE
    } loaderStateT;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [7:0] DONE_BYTE_DEFAULT = 8'h5A;
    localparam int         ADDR_W_DEFAULT    = 16;

    // A zero length byte stands for a full 256-byte page.
    localparam bit LEN_ZERO_IS_256 = 1'b1;

    function automatic logic [8:0] lenToCount(input logic [7:0] lenByte);
        if (lenByte == 8'h00 && LEN_ZERO_IS_256)
            return 9'd256;
        return {1'b0, lenByte};
    endfunction

endpackage

// File: rtl/cart_loader_csum.sv
// 8-bit modulo-256 accumulator used to verify frame checksums.
// oZero reports whether the running sum plus the byte on iData wraps to zero.
module cart_loader_csum (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iClear,
    input  logic       iAdd,
    input  logic [7:0] iData,
    output logic       oZero
);

    logic [7:0] acc;
    logic [7:0] sumNext;

    assign sumNext = acc + iData;
    assign oZero   = (sumNext == 8'h00);

    always_ff @(posedge iClock) begin
        if (iReset)
            acc <= 8'h00;
        else if (iClear)
            acc <= 8'h00;
        else if (iAdd)
            acc <= sumNext;
    end

endmodule

// File: rtl/cart_loader.sv
// Framed byte-stream loader that writes payload into MMU space and holds the CPU in reset.
// Define CART_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte per frame.
module cart_loader
    import cart_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter logic [7:0] DONE_BYTE = DONE_BYTE_DEFAULT,
    parameter int         ADDR_W    = ADDR_W_DEFAULT
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [7:0]        iData,
    input  logic              iValid,
    output logic              oReady,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [7:0]        oMemData,
    output logic              oMemWe,
    output logic              oCpuReset,
    output logic              oBusy,
    output logic              oError,
    output logic [7:0]        oFrameCount
);

    loaderStateT       state;
    loaderStateT       stateNext;
    logic              accept;
    logic              lastByte;
    logic              frameOk;
    logic [ADDR_W-1:0] ptr;
    logic [8:0]        remaining;

    assign accept   = iValid && (state != DONE);
    assign lastByte = (remaining == 9'd1);

`ifdef CART_LOADER_CHECKSUM_EN
    logic csumClear;
    logic csumAdd;
    logic csumZero;
    logic errorReg;

    assign csumClear = accept && (state == IDLE) && (iData == SYNC_BYTE);
    assign csumAdd   = accept && (state inside {ADDR_H, ADDR_L, LEN, DATA});
    assign frameOk   = accept && (state == CHK) && csumZero;
    assign oError    = errorReg;

    cart_loader_csum uCsum (
        .iClock (iClock),
        .iReset (iReset),
        .iClear (csumClear),
        .iAdd   (csumAdd),
        .iData  (iData),
        .oZero  (csumZero)
    );

    // Sticky until the next accepted sync; bytes already written stay written.
    always_ff @(posedge iClock) begin
        if (iReset)
            errorReg <= 1'b0;
        else if (csumClear)
            errorReg <= 1'b0;
        else if (accept && (state == CHK) && !csumZero)
            errorReg <= 1'b1;
    end
`else
    assign frameOk = accept && (state == DATA) && lastByte;
    assign oError  = 1'b0;
`endif

    always_ff @(posedge iClock) begin
        if (iReset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (iData == SYNC_BYTE)
                        stateNext = ADDR_H;
                    else if (iData == DONE_BYTE)
                        stateNext = DONE;
                end
                ADDR_H: stateNext = ADDR_L;
                ADDR_L: stateNext = LEN;
                LEN:    stateNext = DATA;
                DATA: begin
                    if (lastByte) begin
`ifdef CART_LOADER_CHECKSUM_EN
                        stateNext = CHK;
`else
                        stateNext = IDLE;
`endif
                    end
                end
                CHK:     stateNext = IDLE;
                default: stateNext = state;
            endcase
        end
    end

    always_comb begin
        oReady    = (state != DONE);
        oCpuReset = (state != DONE);
        oBusy     = !((state == IDLE) || (state == DONE));
    end

    // Pointer, length and the registered write port; the strobe lasts one cycle per data byte.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            ptr         <= '0;
            remaining   <= 9'd0;
            oMemAddr    <= '0;
            oMemData    <= 8'h00;
            oMemWe      <= 1'b0;
            oFrameCount <= 8'h00;
        end else begin
            oMemWe <= 1'b0;
            if (frameOk)
                oFrameCount <= oFrameCount + 8'd1;
            if (accept) begin
                case (state)
                    ADDR_H: ptr <= ADDR_W'({iData, ptr[7:0]});
                    ADDR_L: ptr <= {ptr[ADDR_W-1:8], iData};
                    LEN:    remaining <= lenToCount(iData);
                    DATA: begin
                        oMemWe    <= 1'b1;
                        oMemAddr  <= ptr;
                        oMemData  <= iData;
                        ptr       <= ptr + ADDR_W'(1);
                        remaining <= remaining - 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
